key_search_scheduler: RTL and testbench
=======================================

# key_search_scheduler

Hands out RC4 secret-key candidates to NUM_CORES parallel decrypt cores, each with its own S/message/decrypt memories, so the 22-bit key space is searched in parallel. Grants one key per cycle through an arbitrated request/grant handshake and tracks which key each core is working on. On the first reported match it latches the winning key and aborts all cores. It sits between the top-level HEX/LEDR display logic and the array of crack cores.

## Interface
- NUM_CORES, 4, number of crack cores (2..8)
- KEY_WIDTH, 24, secret key width
- KEY_MAX, 24'h3FFFFF, last key candidate issued

- clk  in  1  system clock (CLOCK_50)
- reset  in  1  one clock; reset is synchronous and active-high
- start  in  1  pulse; begins a search from key 0
- key_req  in  NUM_CORES  per-core level request for a new key
- core_done  in  NUM_CORES  per-core 1-cycle pulse: current key finished
- core_match  in  NUM_CORES  qualified by core_done: key decrypted to valid text
- key_gnt  out  NUM_CORES  one-hot grant, 1-cycle pulse, registered
- key_out  out  KEY_WIDTH  granted key, valid only while key_gnt != 0
- abort  out  1  level; cores must stop and idle
- busy  out  1  search in progress
- match_found  out  1  level; drives LEDR[1]
- all_keys_checked  out  1  level; exhausted without match, drives LEDR[0]
- found_key  out  KEY_WIDTH  winning key, valid while match_found

## Operation
- States: IDLE, DISPATCH, DRAIN, FOUND, EXHAUSTED.
- Internal: next_key (KEY_WIDTH), outstanding[NUM_CORES], core_key[i] (key last granted to core i), rr_ptr.
- IDLE: all outputs 0. start -> DISPATCH; next_key<=0, outstanding<=0, rr_ptr<=0.
- DISPATCH: eligible = key_req & ~outstanding. If eligible != 0, pick one core i. Next cycle key_gnt[i]=1, key_out=next_key. Same edge: core_key[i]<=next_key, outstanding[i]<=1, next_key<=next_key+1. If the granted key == KEY_MAX -> DRAIN.
- core_done[j] with outstanding[j]=1 clears outstanding[j]. core_done on a non-outstanding core is ignored, including its core_match.
- Match: core_done[j] & core_match[j] & outstanding[j] in DISPATCH or DRAIN -> FOUND. found_key<=core_key[j]. Multiple simultaneous matches: lowest j wins. No grant is issued in the match cycle.
- DRAIN: no grants. outstanding==0 with no match -> EXHAUSTED.
- FOUND: match_found=1, abort=1, busy=0. Held until reset or start.
- EXHAUSTED: all_keys_checked=1, busy=0. Held until reset or start.
- start in FOUND or EXHAUSTED: clears match_found, all_keys_checked and found_key, then restarts as from IDLE. start is ignored in DISPATCH and DRAIN.
- busy=1 exactly in DISPATCH and DRAIN.
- next_key never wraps; KEY_MAX is always the last key issued.

## Timing
- Reset: state=IDLE. key_gnt=0, key_out=0, abort=0, busy=0, match_found=0, all_keys_checked=0, found_key=0.
- Reset mid-search: everything cleared at the next edge; in-flight core results are discarded.
- Grant latency: key_gnt rises 1 cycle after key_req is sampled eligible. The requesting core is masked from the grant edge onward, so holding key_req one extra cycle does not cause a double grant.
- Throughput: at most 1 grant per cycle across all cores.
- A grant to one core and core_done from another in the same cycle are both honoured.
- FOUND/EXHAUSTED flags assert 1 cycle after the deciding core_done or outstanding==0 condition.

## Configuration
- KEY_SCHED_ROUND_ROBIN_EN defined: round-robin arbitration. Search starts at rr_ptr; after a grant to core i, rr_ptr<=(i+1) mod NUM_CORES.
- Undefined: fixed priority, lowest eligible index wins, and rr_ptr is unused.
- The port list is identical in both builds.

## Test plan
- Reset, then start; all 4 cores hold key_req -> keys 0,1,2,3 granted on 4 consecutive cycles, one-hot, to cores 0,1,2,3.
- Round-robin build: cores 0 and 2 request continuously with 1-cycle done turnaround -> grants alternate 0,2,0,2. Fixed build, same stimulus with cores 0 and 2 requesting every cycle -> core 0 wins each time both are eligible.
- KEY_MAX=24'h00000F, no matches -> last grant key_out=0x0F, DRAIN, then all_keys_checked=1 one cycle after the final core_done; no further grants.
- Core 2 holds key 0x000005, cores 1 and 2 report a match in the same cycle -> found_key = core 1's key, match_found=1, abort=1, busy=0.
- core_done with core_match on a core that has no outstanding key -> ignored, search continues. Request held across the grant cycle -> exactly one grant.
- Reset asserted mid-DISPATCH, then start -> first grant is key 0 and all flags are 0.

Source files
------------

// File: rtl/key_search_scheduler.sv
// key_search_scheduler: hands RC4 key candidates to NUM_CORES crack cores and latches the first matching key.
// Latency: key_gnt/key_out one cycle after key_req is sampled eligible; FOUND/EXHAUSTED flags one cycle after the deciding core_done.
// Backpressure: a core stays masked until its core_done returns; at most one grant per cycle; grants stop on match or after KEY_MAX.
// Build option: define KEY_SCHED_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest eligible index wins.
module key_search_scheduler #(
  parameter int                   NUM_CORES = 4,
  parameter int                   KEY_WIDTH = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX   = 'h3FFFFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_CORES-1:0] key_req,
  input  logic [NUM_CORES-1:0] core_done,
  input  logic [NUM_CORES-1:0] core_match,
  output logic [NUM_CORES-1:0] key_gnt,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 abort,
  output logic                 busy,
  output logic                 match_found,
  output logic                 all_keys_checked,
  output logic [KEY_WIDTH-1:0] found_key
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    DISPATCH,
    DRAIN,
    FOUND,
    EXHAUSTED
  } state_t;

  state_t               state;
  logic [KEY_WIDTH-1:0] next_key;
  logic [NUM_CORES-1:0] outstanding;
  logic [KEY_WIDTH-1:0] core_key [NUM_CORES];

  logic [NUM_CORES-1:0] eligible;
  logic [NUM_CORES-1:0] hit;
  logic [NUM_CORES-1:0] out_cleared;
  logic [NUM_CORES-1:0] pick_oh;
  logic                 pick_vld;
  logic                 hit_vld;
  logic                 last_key;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     hit_idx;

  // A core that already holds a key is masked from the grant edge until its done pulse.
  assign eligible    = key_req & ~outstanding;
  // Results from cores without an outstanding key are stale and ignored.
  assign hit         = core_done & outstanding & core_match;
  assign hit_vld     = |hit;
  assign out_cleared = outstanding & ~core_done;
  assign last_key    = (next_key == KEY_MAX);
  assign pick_oh     = pick_vld ? (NUM_CORES'(1) << pick_idx) : '0;

  // Lowest-index reported match wins when several cores hit together.
  always_comb begin
    hit_idx = '0;
    for (int j = NUM_CORES - 1; j >= 0; j--) begin
      if (hit[j]) hit_idx = IDX_W'(j);
    end
  end

`ifdef KEY_SCHED_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_next;
  logic [IDX_W:0]   rr_sum;
  logic [IDX_W-1:0] rr_idx;

  // Scan from rr_ptr upward with wrap; the last write is the eligible core nearest rr_ptr.
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    rr_sum   = '0;
    rr_idx   = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      rr_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (rr_sum >= (IDX_W+1)'(NUM_CORES)) rr_sum = rr_sum - (IDX_W+1)'(NUM_CORES);
      rr_idx = rr_sum[IDX_W-1:0];
      if (eligible[rr_idx]) begin
        pick_idx = rr_idx;
        pick_vld = 1'b1;
      end
    end
  end

  // Pointer moves just past the core that was granted.
  assign rr_next = (pick_idx == IDX_W'(NUM_CORES - 1)) ? '0 : pick_idx + 1'b1;
`else
  // Fixed priority: lowest eligible index wins.
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (eligible[k]) begin
        pick_idx = IDX_W'(k);
        pick_vld = 1'b1;
      end
    end
  end
`endif

  // Search state machine with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      next_key         <= '0;
      outstanding      <= '0;
      key_gnt          <= '0;
      key_out          <= '0;
      abort            <= 1'b0;
      busy             <= 1'b0;
      match_found      <= 1'b0;
      all_keys_checked <= 1'b0;
      found_key        <= '0;
      for (int i = 0; i < NUM_CORES; i++) core_key[i] <= '0;
`ifdef KEY_SCHED_ROUND_ROBIN_EN
      rr_ptr           <= '0;
`endif
    end else begin
      key_gnt <= '0;
      key_out <= '0;
      case (state)
        IDLE, FOUND, EXHAUSTED: begin
          // start always begins a fresh search from key 0 and clears the result flags.
          if (start) begin
            state            <= DISPATCH;
            next_key         <= '0;
            outstanding      <= '0;
            busy             <= 1'b1;
            abort            <= 1'b0;
            match_found      <= 1'b0;
            all_keys_checked <= 1'b0;
            found_key        <= '0;
`ifdef KEY_SCHED_ROUND_ROBIN_EN
            rr_ptr           <= '0;
`endif
          end
        end

        DISPATCH, DRAIN: begin
          outstanding <= out_cleared;
          if (hit_vld) begin
            // A match takes precedence over any grant in the same cycle.
            state       <= FOUND;
            found_key   <= core_key[hit_idx];
            match_found <= 1'b1;
            abort       <= 1'b1;
            busy        <= 1'b0;
          end else if (state == DISPATCH) begin
            if (pick_vld) begin
              key_gnt            <= pick_oh;
              key_out            <= next_key;
              core_key[pick_idx] <= next_key;
              outstanding        <= out_cleared | pick_oh;
              next_key           <= next_key + KEY_WIDTH'(1);
`ifdef KEY_SCHED_ROUND_ROBIN_EN
              rr_ptr             <= rr_next;
`endif
              if (last_key) state <= DRAIN;
            end
          end else if (out_cleared == '0) begin
            // Every key has been returned with no match.
            state            <= EXHAUSTED;
            busy             <= 1'b0;
            all_keys_checked <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_search_scheduler.sv
// Bench for key_search_scheduler: directed steps then randomized traffic against a reference model.
// The model tracks which key each core owns and the search mode, and predicts every output after each edge.
module tb_key_search_scheduler;

  localparam int            NC   = 4;
  localparam int            KW   = 24;
  localparam logic [KW-1:0] KMAX = 24'h00000F;

  localparam int M_IDLE  = 0;
  localparam int M_DISP  = 1;
  localparam int M_DRAIN = 2;
  localparam int M_FOUND = 3;
  localparam int M_EXH   = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [NC-1:0] key_req;
  logic [NC-1:0] core_done;
  logic [NC-1:0] core_match;
  logic [NC-1:0] key_gnt;
  logic [KW-1:0] key_out;
  logic          abort;
  logic          busy;
  logic          match_found;
  logic          all_keys_checked;
  logic [KW-1:0] found_key;

  key_search_scheduler #(
    .NUM_CORES(NC),
    .KEY_WIDTH(KW),
    .KEY_MAX  (KMAX)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .key_req         (key_req),
    .core_done       (core_done),
    .core_match      (core_match),
    .key_gnt         (key_gnt),
    .key_out         (key_out),
    .abort           (abort),
    .busy            (busy),
    .match_found     (match_found),
    .all_keys_checked(all_keys_checked),
    .found_key       (found_key)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model state: search mode, key owned by each core (-1 = none), next key, rotation start.
  int            m_mode;
  int            m_own [NC];
  int            m_next;
  int            m_rr;
  logic [NC-1:0] exp_gnt;
  logic [KW-1:0] exp_key;
  logic [KW-1:0] exp_fk;
  logic [KW-1:0] last_key;
  logic [NC-1:0] prev_g;
  logic [NC-1:0] om;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [NC-1:0] own_mask();
    logic [NC-1:0] m = '0;
    for (int j = 0; j < NC; j++) if (m_own[j] >= 0) m[j] = 1'b1;
    return m;
  endfunction

  function automatic int arbitrate();
    int first = -1;
`ifdef KEY_SCHED_ROUND_ROBIN_EN
    for (int k = 0; k < NC; k++) begin
      int j;
      j = (m_rr + k) % NC;
      if (first < 0 && key_req[j] && m_own[j] < 0) first = j;
    end
`else
    for (int j = 0; j < NC; j++) if (first < 0 && key_req[j] && m_own[j] < 0) first = j;
`endif
    return first;
  endfunction

  task automatic model_restart();
    m_mode = M_DISP;
    m_next = 0;
    m_rr   = 0;
    exp_fk = '0;
    for (int j = 0; j < NC; j++) m_own[j] = -1;
  endtask

  // Predict the outputs produced by the coming clock edge and advance the model.
  task automatic model_edge();
    int win;
    int pick;
    win     = -1;
    pick    = -1;
    exp_gnt = '0;
    exp_key = '0;
    if (reset) begin
      model_restart();
      m_mode = M_IDLE;
    end else if (m_mode == M_IDLE || m_mode == M_FOUND || m_mode == M_EXH) begin
      if (start) model_restart();
    end else begin
      for (int j = 0; j < NC; j++)
        if (win < 0 && core_done[j] && core_match[j] && m_own[j] >= 0) win = j;
      if (win < 0 && m_mode == M_DISP) pick = arbitrate();
      if (win >= 0) begin
        exp_fk = KW'(m_own[win]);
        m_mode = M_FOUND;
      end
      for (int j = 0; j < NC; j++) if (core_done[j]) m_own[j] = -1;
      if (pick >= 0) begin
        m_own[pick]   = m_next;
        exp_gnt[pick] = 1'b1;
        exp_key       = KW'(m_next);
        if (m_next == int'(KMAX)) m_mode = M_DRAIN;
        m_next++;
        m_rr = (pick + 1) % NC;
      end
      if (m_mode == M_DRAIN && pick < 0 && own_mask() == '0) m_mode = M_EXH;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    if (key_gnt != '0) last_key = key_out;
    check("key_gnt", 32'(key_gnt), 32'(exp_gnt));
    check("key_out", 32'(key_out), 32'(exp_key));
    check("busy", 32'(busy), 32'(m_mode == M_DISP || m_mode == M_DRAIN));
    check("abort", 32'(abort), 32'(m_mode == M_FOUND));
    check("match_found", 32'(match_found), 32'(m_mode == M_FOUND));
    check("all_keys_checked", 32'(all_keys_checked), 32'(m_mode == M_EXH));
    check("found_key", 32'(found_key), 32'(exp_fk));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    key_req    = '0;
    core_done  = '0;
    core_match = '0;
    last_key   = '0;
    prev_g     = '0;
    om         = '0;
    model_restart();
    m_mode = M_IDLE;

    // Reset state
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_found_key", 32'(found_key), 32'd0);

    // Start with all cores requesting: keys 0..3 to cores 0..3 on consecutive cycles
    reset   = 1'b0;
    start   = 1'b1;
    key_req = '1;
    step();
    check("start_busy", 32'(busy), 32'd1);
    start = 1'b0;
    for (int i = 0; i < NC; i++) begin
      step();
      check("seq_gnt", 32'(key_gnt), 32'(1) << i);
      check("seq_key", 32'(key_out), 32'(i));
    end
    step();
    check("held_req_no_regrant", 32'(key_gnt), 32'd0);

    // Cores 0 and 2 with 1-cycle done turnaround: grants alternate 0,2,0,2 with keys 4..9
    core_done = '1;
    key_req   = '0;
    step();
    key_req = 4'b0101;
    prev_g  = '0;
    for (int i = 0; i < 6; i++) begin
      core_done = prev_g;
      step();
      prev_g = exp_gnt;
      check("alt_gnt", 32'(key_gnt), (i % 2 == 0) ? 32'd1 : 32'd4);
      check("alt_key", 32'(key_out), 32'(4 + i));
    end

    // Done+match on a core with no outstanding key is ignored
    key_req    = '0;
    core_done  = 4'b0010;
    core_match = 4'b0010;
    step();
    check("stray_match_ignored", 32'(match_found), 32'd0);
    check("stray_busy", 32'(busy), 32'd1);
    core_match = '0;
    core_done  = 4'b0100;
    step();

    // Reset mid-search, then start: first grant is key 0 to core 0
    core_done = '0;
    reset     = 1'b1;
    step();
    reset   = 1'b0;
    start   = 1'b1;
    key_req = '1;
    step();
    start = 1'b0;
    step();
    check("post_reset_gnt", 32'(key_gnt), 32'd1);
    check("post_reset_key", 32'(key_out), 32'd0);
    check("post_reset_flags", 32'({abort, match_found, all_keys_checked}), 32'd0);
    step();
    step();
    step();

    // Core 1 holds key 4, core 2 holds key 5; both match together -> core 1 wins, no grant
    key_req   = '0;
    core_done = 4'b0110;
    step();
    core_done = '0;
    key_req   = 4'b0010;
    step();
    key_req = 4'b0100;
    step();
    check("core2_key", 32'(key_out), 32'h5);
    key_req   = '0;
    core_done = 4'b0001;
    step();
    key_req    = '1;
    core_done  = 4'b0110;
    core_match = 4'b0110;
    step();
    check("match_found_key", 32'(found_key), 32'h4);
    check("match_flag", 32'(match_found), 32'd1);
    check("match_abort", 32'(abort), 32'd1);
    check("match_busy", 32'(busy), 32'd0);
    check("match_no_grant", 32'(key_gnt), 32'd0);
    core_done  = '0;
    core_match = '0;
    step();
    check("found_held", 32'(match_found), 32'd1);

    // start in FOUND clears the result and restarts
    key_req = '0;
    start   = 1'b1;
    step();
    start = 1'b0;
    check("restart_clear_match", 32'(match_found), 32'd0);
    check("restart_clear_key", 32'(found_key), 32'd0);

    // Exhaustion: run to KEY_MAX, drain, then all_keys_checked one cycle after final done
    last_key = '0;
    key_req  = '1;
    for (int i = 0; i < 64 && m_mode == M_DISP; i++) begin
      core_done = own_mask();
      step();
    end
    check("last_key_is_max", 32'(last_key), 32'(KMAX));
    core_done = '0;
    step();
    step();
    check("drain_no_grant", 32'(key_gnt), 32'd0);
    check("drain_busy", 32'(busy), 32'd1);
    check("drain_not_done", 32'(all_keys_checked), 32'd0);
    core_done = own_mask();
    step();
    check("exhausted_flag", 32'(all_keys_checked), 32'd1);
    check("exhausted_busy", 32'(busy), 32'd0);
    core_done = '0;
    step();
    check("exhausted_no_grant", 32'(key_gnt), 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      om         = own_mask();
      reset      = ($urandom_range(0, 299) == 0);
      start      = ($urandom_range(0, 19) == 0);
      key_req    = NC'($urandom);
      core_done  = NC'($urandom) & om;
      if ($urandom_range(0, 9) == 0) core_done = core_done | (NC'($urandom) & ~om);
      core_match = (NC'($urandom) & ~om) |
                   (NC'($urandom) & NC'($urandom) & NC'($urandom) & NC'($urandom) & om);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
